// File: rtl/pipe_hazard_ctl_pkg.sv
// Shared types and size helpers for the decode-stage hazard/forwarding controller.
package pipe_pkg;

    // Tag rn is sized for the widest supported register file; narrower RAW is zero-extended.
    localparam int unsigned RAW_MAX = 8;
    localparam int unsigned FWD_RF  = 0;

    typedef struct packed {
        logic               wreg;
        logic               m2reg;
        logic [RAW_MAX-1:0] rn;
    } tag_t;

    function automatic int unsigned depth_of(input int unsigned mem_lat);
        return mem_lat + 2;
    endfunction

    function automatic int unsigned sw_of(input int unsigned mem_lat);
        return $clog2(mem_lat + 3);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctl_fwd_pick.sv
// Picks the youngest in-flight producer of one source register and reports its readiness.
module fwd_pick
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned SW      = 2
) (
    input  tag_t [DEPTH:1]     tags_i,
    input  logic [RAW_MAX-1:0] src_i,
    input  logic               use_i,
    output logic [SW-1:0]      sel_o,
    output logic               ready_o,
    output logic               hit_o
);

    always_comb begin
        sel_o   = SW'(FWD_RF);
        ready_o = 1'b1;
        hit_o   = 1'b0;
        // Ascending scan; the first hit is the youngest producer and later ones are ignored.
        for (int unsigned i = 1; i <= DEPTH; i++) begin
            if (!hit_o && use_i && tags_i[i].wreg && (tags_i[i].rn == src_i) && (src_i != '0)) begin
                hit_o   = 1'b1;
                sel_o   = SW'(i);
                ready_o = ~tags_i[i].m2reg | (i >= MEM_LAT + 1);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Decode-stage hazard controller: tag pipeline, operand forwarding selects, load-use stall, branch flush.
module pipe_hazard_ctl
    import pipe_pkg::*;
#(
    parameter int unsigned  MEM_LAT  = 1,
    parameter int unsigned  RAW      = 5,
    parameter bit           FLUSH_BR = 1'b1,
    localparam int unsigned DEPTH    = depth_of(MEM_LAT),
    localparam int unsigned SW       = sw_of(MEM_LAT)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [RAW-1:0] d_rs,
    input  logic [RAW-1:0] d_rt,
    input  logic           d_use_rs,
    input  logic           d_use_rt,
    input  logic           d_wreg,
    input  logic           d_m2reg,
    input  logic [RAW-1:0] d_rn,
    input  logic           d_jump,
    output logic [SW-1:0]  fwa,
    output logic [SW-1:0]  fwb,
    output logic           wpcir,
    output logic           e_kill,
    output logic           dbubble
);

    tag_t [DEPTH:1] tags_q, tags_d;
    logic [SW-1:0]  sel_a, sel_b;
    logic           rdy_a, rdy_b, hit_a, hit_b;
    logic           hazard;

    fwd_pick #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT), .SW(SW)) u_pick_a (
        .tags_i  (tags_q),
        .src_i   (RAW_MAX'(d_rs)),
        .use_i   (d_use_rs),
        .sel_o   (sel_a),
        .ready_o (rdy_a),
        .hit_o   (hit_a)
    );

    fwd_pick #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT), .SW(SW)) u_pick_b (
        .tags_i  (tags_q),
        .src_i   (RAW_MAX'(d_rt)),
        .use_i   (d_use_rt),
        .sel_o   (sel_b),
        .ready_o (rdy_b),
        .hit_o   (hit_b)
    );

    // A stall lasts exactly as long as either youngest producer is an unfinished load.
    assign hazard  = (hit_a & ~rdy_a) | (hit_b & ~rdy_b);
    assign fwa     = sel_a;
    assign fwb     = sel_b;
    assign wpcir   = ~hazard;
    assign e_kill  = hazard;
    assign dbubble = FLUSH_BR & d_jump & ~hazard;

    always_comb begin
        tags_d = '0;
        if (!hazard) begin
            tags_d[1] = tag_t'{wreg: d_wreg, m2reg: d_m2reg, rn: RAW_MAX'(d_rn)};
        end
        for (int unsigned i = 2; i <= DEPTH; i++) begin
            tags_d[i] = tags_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tags_q <= '0;
        end else begin
            tags_q <= tags_d;
        end
    end

endmodule

// File: doc/pipe_hazard_ctl.md
# pipe_hazard_ctl

Parametrised hazard and forwarding controller for the pipelined CPU's decode stage. It tracks the destination registers of every in-flight instruction in its own tag pipeline. From that it produces per-operand forwarding selects, the load-use interlock (`wpcir` low plus a bubble into EX) and the branch-flush bubble. It generalises the fixed 5-stage logic to a configurable memory latency and an optional branch-flush mode, and sits beside the ID stage feeding the operand muxes and the IF/ID register.

## Interface
- `MEM_LAT`, 1: number of MEM cycles before load data is valid, 1–4; tag pipeline depth `DEPTH = MEM_LAT+2` (E, M1..Mk, W).
- `RAW`, 5: register address width; register 0 is hardwired zero.
- `FLUSH_BR`, 1: 1 means a taken branch/jump in ID kills the instruction in IF; 0 means delay-slot mode, no kill.
- `SW`, `$clog2(DEPTH+1)`: forward-select width (derived, not overridden).

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `d_rs`, `d_rt` in RAW: source registers of the instruction in ID.
- `d_use_rs`, `d_use_rt` in 1: the ID instruction actually reads rs/rt.
- `d_wreg`, `d_m2reg` in 1: the ID instruction writes a register / is a load.
- `d_rn` in RAW: destination register of the ID instruction.
- `d_jump` in 1: the ID instruction redirects the PC this cycle (pcsource≠0).
- `fwa`, `fwb` out SW: operand source. 0 is the regfile, i is stage i (1=E, 2..MEM_LAT+1=M1..Mk, DEPTH=W).
- `wpcir` out 1: 1 means PC and IF/ID advance; 0 means hold.
- `e_kill` out 1: zero the control bits latched into ID/EX.
- `dbubble` out 1: zero the instruction latched into IF/ID.

## Operation
- The tag pipeline holds one entry per stage, 1..DEPTH, with fields {wreg, m2reg, rn}. It shifts every cycle; the back end never stalls.
  - Entry 1 loads {d_wreg, d_m2reg, d_rn} when `wpcir`=1, else zeros.
  - Entry i+1 loads entry i. Entry DEPTH drops off.
- Match for stage i on source s: `wreg_i & rn_i==s & rn_i!=0 & d_use_s`.
- Ready for stage i: `!m2reg_i | i>=MEM_LAT+1`. ALU results are ready from E; load data is ready from the last M stage.
- `fwa` is the lowest-index (youngest) matching stage, else 0. `fwb` is computed the same way on rt. Older matches are ignored.
- Hazard: the youngest matching stage for either operand is not ready.
  - Outputs: `wpcir`=0, `e_kill`=1.
  - `fwa`/`fwb` still report that stage; consumers discard them because of `e_kill`.
- Stall length is data-driven: the load-use distance-1 case stalls exactly MEM_LAT cycles. Distance d stalls max(0, MEM_LAT+1−d) cycles.
- Branch: `dbubble = FLUSH_BR & d_jump & wpcir`. A jump held in ID by a stall does not flush until its stall clears. It then flushes exactly once, because the IF/ID advance moves it out of ID.
- `d_jump` without the stall qualifier is never used; double flushes are forbidden.
- Reset clears all tag entries.
  - Outputs: `fwa`=`fwb`=0, `wpcir`=1, `e_kill`=0, `dbubble`=0.
  - Reset asserted mid-stall clears the stall the next cycle.

## Timing
- Tags are registered; all outputs are combinational from tags and ID inputs within the same cycle, with no added latency.
- Write-back stage W forwards (sel=DEPTH) so a same-cycle regfile write is never missed.
- Simultaneous rs and rt hazards on different producers: the stall lasts until both are ready; no separate counters.
- A branch in ID whose operand is a not-ready load stalls first, then resolves with forwarded data.

## Structure
- The shared package `pipe_pkg` holds the stage tag struct {wreg, m2reg, rn[RAW-1:0]}, `FWD_RF=0` and the `DEPTH`/`SW` derivation functions.
- One sub-module, `fwd_pick`, is instantiated twice (rs, rt). It takes the tag array and a source register, and returns {sel, ready, hit}. The top module holds the tag shift register, stall and flush logic.

## Test plan
- **Load-use, MEM_LAT=1.** Stimulus: `lw r3`, then `add r4,r3,r5` in ID next cycle. Required: `wpcir`=0 and `e_kill`=1 for 1 cycle, then `fwa`=2 (M1), `fwb`=0.
- **Load-use, MEM_LAT=3.** Same sequence. Required: a 3-cycle stall, then `fwa`=4. With one independent instruction between the load and its use: a 2-cycle stall.
- **ALU chain.** Stimulus: `add r1`; `sub r1`; `or r2,r1,r1`. Required: `fwa`=`fwb`=1 (youngest E wins over M1), no stall.
- **Register zero.** Stimulus: a producer writing r0, then a consumer of r0. Required: `fwa`=0, no stall.
- **Branch behind load, FLUSH_BR=1.** Stimulus: `lw r2`; `beq r2,r0` taken. Required: `dbubble`=0 during the stall, then `dbubble`=1 for exactly one cycle. With FLUSH_BR=0: `dbubble` never asserts.
- **Reset mid-stall.** Stimulus: `reset` pulsed during a MEM_LAT=3 stall. Required: next cycle `wpcir`=1, `e_kill`=0, all tags 0, `fwa`=`fwb`=0.
